// File: rtl/axis_burst_drain.sv
// Burst drain: pops BURST_LEN beats once the FIFO holds them and re-emits them with tlast on the last beat (BURST_DRAIN_TIMEOUT_EN adds a partial-burst flush).
// Latency: 1 cycle from a FIFO pop to m_axis_tvalid; 1 beat/cycle within a burst.
// Backpressure: s_axis_tready only in BURST while the output slot is empty or draining; the slot holds while m_axis_tready is low.
module axis_burst_drain #(
  parameter int width          = 16,
  parameter int BURST_LEN      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fifo_count,
  input  logic [width-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [width-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             busy,
  output logic [31:0]      bursts_done
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [31:0]   BL32 = 32'(BURST_LEN);
  localparam logic [CW-1:0] BL_Q = CW'(BURST_LEN);

  if (BURST_LEN < 1) begin : g_bad_len
    $error("BURST_LEN must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] burst_len_q;
  logic          slot_free;
  logic          s_t;
  logic          m_t;
  logic          last_beat;
  logic          timeout_hit;

  assign slot_free     = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == BURST) && slot_free;
  assign s_t           = s_axis_tvalid && s_axis_tready;
  assign m_t           = m_axis_tvalid && m_axis_tready;
  assign last_beat     = (beat_cnt == burst_len_q - CW'(1));
  assign busy          = (state != IDLE) || m_axis_tvalid;

`ifdef BURST_DRAIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_timer;
  logic          partial;

  // Only a stranded remainder (non-empty, below a full burst) ages toward a flush.
  assign partial     = (state == IDLE) && (fifo_count != 32'd0) && (fifo_count < BL32);
  assign timeout_hit = partial && (idle_timer == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || !partial) begin
      idle_timer <= '0;
    end else if (!timeout_hit) begin
      idle_timer <= idle_timer + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      burst_len_q   <= BL_Q;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      bursts_done   <= '0;
    end else begin
      if (s_t) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= last_beat;
      end else if (m_t) begin
        m_axis_tvalid <= 1'b0;
      end

      if (m_t && m_axis_tlast) begin
        bursts_done <= bursts_done + 32'd1;
      end

      case (state)
        IDLE: begin
          if (fifo_count >= BL32) begin
            burst_len_q <= BL_Q;
            beat_cnt    <= '0;
            state       <= BURST;
          end else if (timeout_hit) begin
            burst_len_q <= fifo_count[CW-1:0];
            beat_cnt    <= '0;
            state       <= BURST;
          end
        end
        BURST: begin
          if (s_t) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= GAP;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        // fifo_count is registered upstream, so give it one cycle to see the final pop.
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_burst_drain.sv
// Bench for axis_burst_drain: queue-based FIFO model feeding the DUT and a burst-grouping scoreboard on the output.
module tb_axis_burst_drain;
  localparam int W  = 16;
  localparam int BL = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  fifo_count;
  logic [W-1:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic         busy;
  logic [31:0]  bursts_done;

  always #5 clk = ~clk;

  axis_burst_drain #(.width(W), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .fifo_count(fifo_count),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy(busy), .bursts_done(bursts_done)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] fifo_q[$];   // upstream FIFO contents
  logic [W-1:0] pend_q[$];   // words not yet forming a full burst
  logic [W-1:0] exp_q[$];    // words expected downstream, in order
  int           beats_out;
  int           exp_bursts;
  int           ready_sel;   // 0 always ready, 1 toggling, 2 random
  int           cyc;
  bit           sb_on;
  bit           prev_stall;
  logic [W-1:0] prev_dat;
  logic         prev_last;
  bit           last_mt;
  logic [W-1:0] last_d;
  logic         last_l;
  int           first_mt_cyc;
  int           last_mt_cyc;

  task automatic refresh();
    fifo_count    = 32'(fifo_q.size());
    s_axis_tvalid = (fifo_q.size() != 0);
    s_axis_tdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [W-1:0] d);
    fifo_q.push_back(d);
    pend_q.push_back(d);
    if (pend_q.size() == BL) begin
      foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      pend_q.delete();
    end
    refresh();
  endtask

  // One clock: choose ready, check stall stability and output beats, then pop the model FIFO.
  task automatic cycle();
    bit s_t, m_t;
    logic [W-1:0] ed;
    logic el;
    case (ready_sel)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (cyc % 2 == 0);
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (prev_stall) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_dat || m_axis_tlast !== prev_last) begin
        failures++;
        $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_dat, prev_last);
      end
    end
    s_t = s_axis_tvalid && s_axis_tready;
    m_t = m_axis_tvalid && m_axis_tready;
    last_mt = m_t;
    last_d  = m_axis_tdata;
    last_l  = m_axis_tlast;
    if (m_t && sb_on) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL extra_beat got d=%h l=%b exp no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        ed = exp_q.pop_front();
        el = ((beats_out % BL) == BL - 1);
        if (m_axis_tdata !== ed || m_axis_tlast !== el) begin
          failures++;
          $display("FAIL beat%0d got d=%h l=%b exp d=%h l=%b", beats_out, m_axis_tdata, m_axis_tlast, ed, el);
        end
        beats_out++;
        if (el) exp_bursts++;
        if (first_mt_cyc < 0) first_mt_cyc = cyc;
        last_mt_cyc = cyc;
      end
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_dat   = m_axis_tdata;
    prev_last  = m_axis_tlast;
    @(posedge clk);
    @(negedge clk);
    if (s_t) void'(fifo_q.pop_front());
    refresh();
    cyc++;
  endtask

  task automatic do_reset();
    fifo_q.delete(); pend_q.delete(); exp_q.delete();
    beats_out = 0; exp_bursts = 0; prev_stall = 0; sb_on = 1;
    first_mt_cyc = -1; last_mt_cyc = -1;
    refresh();
    m_axis_tready = 1'b1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid || fifo_q.size() >= BL) && n < 500) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL %s_drain got %0d beats left after timeout exp 0", name, exp_q.size());
    end
    repeat (6) cycle();
  endtask

  task automatic check_bursts(input string name, input logic [31:0] exp);
    checks++;
    if (bursts_done !== exp) begin
      failures++;
      $display("FAIL %s_bursts_done got %0d exp %0d", name, bursts_done, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 ||
        bursts_done !== 32'd0 || busy !== 1'b0 || s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b l=%b d=%h bd=%0d busy=%b rdy=%b exp all zero",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, bursts_done, busy, s_axis_tready);
    end
  endtask

  task automatic test_partial_hold();
    int bad = 0;
    do_reset();
    for (int i = 1; i <= BL - 1; i++) push(W'(i));
    repeat (50) begin
      cycle();
      #1;
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL partial_hold got %0d active cycles exp 0", bad);
    end
    checks++;
    if (fifo_count !== 32'(BL - 1)) begin
      failures++;
      $display("FAIL partial_hold_count got %0d exp %0d", fifo_count, BL - 1);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    ready_sel = 0;
    for (int i = 0; i < BL; i++) push(W'(16'hA000 + i));
    drain("single");
    check_bursts("single", 32'd1);
    checks++;
    if (beats_out != BL || last_mt_cyc - first_mt_cyc != BL - 1) begin
      failures++;
      $display("FAIL single_contig got beats=%0d span=%0d exp beats=%0d span=%0d",
               beats_out, last_mt_cyc - first_mt_cyc, BL, BL - 1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_sel = 1;
    for (int i = 0; i < 2 * BL; i++) push(W'(16'hB000 + i));
    drain("b2b");
    check_bursts("b2b", 32'd2);
    checks++;
    if (beats_out != 2 * BL) begin
      failures++;
      $display("FAIL b2b_beats got %0d exp %0d", beats_out, 2 * BL);
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    do_reset();
    ready_sel = 2;
    for (int t = 0; t < 400; t++) begin
      if (pushed < 12 && $urandom_range(0, 9) == 0) begin
        for (int i = 0; i < BL; i++) push(W'($urandom()));
        pushed++;
      end
      cycle();
    end
    drain("random");
    check_bursts("random", 32'(exp_bursts));
    checks++;
    if (beats_out != pushed * BL) begin
      failures++;
      $display("FAIL random_beats got %0d exp %0d", beats_out, pushed * BL);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    do_reset();
    ready_sel = 0;
    for (int i = 0; i < BL; i++) push(W'(16'hC000 + i));
    drain("prereset");
    check_bursts("prereset", 32'd1);
    for (int i = 0; i < BL; i++) push(W'(16'hD000 + i));
    while (beats_out < BL + 2 && n < 100) begin cycle(); n++; end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || bursts_done !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got v=%b rdy=%b bd=%0d busy=%b exp 0 0 0 0",
               m_axis_tvalid, s_axis_tready, bursts_done, busy);
    end
  endtask

  task automatic test_timeout_flush();
    int bad = 0;
    int got = 0;
    int n = 0;
    logic [W-1:0] gd[2];
    logic         gl[2];
    do_reset();
    ready_sel = 0;
    sb_on = 0;
    push(16'h55AA);
    push(16'h55AB);
`ifdef BURST_DRAIN_TIMEOUT_EN
    repeat (TO) begin cycle(); if (last_mt) bad++; end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL timeout_early got %0d beats exp 0", bad);
    end
    while (got < 2 && n < 40) begin
      cycle();
      if (last_mt) begin gd[got] = last_d; gl[got] = last_l; got++; end
      n++;
    end
    checks++;
    if (got != 2 || gd[0] !== 16'h55AA || gl[0] !== 1'b0 || gd[1] !== 16'h55AB || gl[1] !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flush got n=%0d d0=%h l0=%b d1=%h l1=%b exp n=2 55aa/0 55ab/1",
               got, gd[0], gl[0], gd[1], gl[1]);
    end
    repeat (4) cycle();
    check_bursts("timeout", 32'd1);
`else
    repeat (50) begin cycle(); if (last_mt) bad++; end
    checks++;
    if (bad != 0 || fifo_count !== 32'd2) begin
      failures++;
      $display("FAIL no_timeout got beats=%0d count=%0d exp beats=0 count=2", bad, fifo_count);
    end
`endif
    sb_on = 1;
  endtask

  task automatic test_wrap();
    do_reset();
    ready_sel = 0;
    force dut.bursts_done = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    release dut.bursts_done;
    #1;
    check_bursts("wrap_preset", 32'hFFFF_FFFF);
    for (int i = 0; i < BL; i++) push(W'(16'hE000 + i));
    drain("wrap");
    check_bursts("wrap", 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    m_axis_tready = 1'b1;
    ready_sel = 0;
    cyc = 0;
    sb_on = 1;
    fifo_q.delete();
    refresh();
    @(negedge clk);
    test_reset();
`ifndef BURST_DRAIN_TIMEOUT_EN
    test_partial_hold();
`endif
    test_single_burst();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_timeout_flush();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
